// File: rtl/debug_cmd_unit_pkg.sv
// Shared definitions for the debug command unit: FSM encoding and the
// command/response byte values of the serial debug protocol.
package debug_cmd_unit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StExec,
    StSend,
    StWaitTx
  } state_e;

  localparam logic [7:0] CmdAck    = 8'h61;  // 'a'
  localparam logic [7:0] CmdStatus = 8'h73;  // 's'
  localparam logic [7:0] CmdRead   = 8'h72;  // 'r'
  localparam logic [7:0] CmdWrite  = 8'h77;  // 'w'
  localparam logic [7:0] RespAck   = 8'h70;  // 'p'
  localparam logic [7:0] RespOk    = 8'h6B;  // 'k'
  localparam logic [7:0] RespErr   = 8'h3F;  // '?'

endpackage

// File: rtl/arg_timer.sv
// Inactivity timer for argument bytes: counts up from a restart and flags
// expiry once ARG_TIMEOUT-1 cycles have elapsed, holding there until restarted.
module arg_timer #(
  parameter int unsigned ARG_TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic expired
);

  localparam int unsigned CntW = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(ARG_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != Last) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == Last);

endmodule

// File: rtl/debug_cmd_unit.sv
// Byte-oriented debug command interpreter: decodes commands from a UART
// receiver, reads/writes a small register file and sends one response byte.
module debug_cmd_unit
  import debug_cmd_unit_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NREGS       = 4,
  parameter int unsigned ARG_TIMEOUT = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       rx_dato_out,
  input  logic                    rx_done,
  input  logic                    tx_done,
  output logic [DATA_W-1:0]       tx_dato_in,
  output logic                    tx_start,
  output logic [NREGS*DATA_W-1:0] reg_file,
  output logic                    busy
);

  localparam logic [DATA_W-1:0] CAck    = DATA_W'(CmdAck);
  localparam logic [DATA_W-1:0] CStatus = DATA_W'(CmdStatus);
  localparam logic [DATA_W-1:0] CRead   = DATA_W'(CmdRead);
  localparam logic [DATA_W-1:0] CWrite  = DATA_W'(CmdWrite);
  localparam logic [DATA_W-1:0] RAck    = DATA_W'(RespAck);
  localparam logic [DATA_W-1:0] ROk     = DATA_W'(RespOk);
  localparam logic [DATA_W-1:0] RErr    = DATA_W'(RespErr);
  localparam logic [DATA_W:0]   NRegsW  = (DATA_W + 1)'(NREGS);

  state_e                       state_q, state_d;
  logic [DATA_W-1:0]            cmd_q, cmd_d;
  logic [DATA_W-1:0]            addr_q, addr_d;
  logic [DATA_W-1:0]            data_q, data_d;
  logic                         args_ok_q, args_ok_d;
  logic [DATA_W-1:0]            tx_data_q, tx_data_d;
  logic [DATA_W-1:0]            ovr_q, ovr_d;
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

  logic              timer_restart;
  logic              timer_expired;
  logic              addr_ok;
  logic [DATA_W-1:0] rd_data;
  logic              ovr_inc;
  logic              ovr_clr;

  // The timer only runs while waiting for an argument byte.
  assign timer_restart = rx_done || !((state_q == StGetAddr) || (state_q == StGetData));

  arg_timer #(
    .ARG_TIMEOUT(ARG_TIMEOUT)
  ) u_arg_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(timer_restart),
    .expired(timer_expired)
  );

  // Full-width compare: out-of-range addresses never alias onto a register.
  assign addr_ok = ({1'b0, addr_q} < NRegsW);

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (addr_q == DATA_W'(i)) begin
        rd_data = regs_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    args_ok_d = args_ok_q;
    tx_data_d = tx_data_q;
    regs_d    = regs_q;

    unique case (state_q)
      StIdle: begin
        if (rx_done) begin
          cmd_d     = rx_dato_out;
          args_ok_d = 1'b0;
          state_d   = StExec;
        end
      end
      StGetAddr: begin
        if (rx_done) begin
          addr_d = rx_dato_out;
          if (cmd_q == CWrite) begin
            state_d = StGetData;
          end else begin
            args_ok_d = 1'b1;
            state_d   = StExec;
          end
        end else if (timer_expired) begin
          tx_data_d = RErr;
          state_d   = StSend;
        end
      end
      StGetData: begin
        if (rx_done) begin
          data_d    = rx_dato_out;
          args_ok_d = 1'b1;
          state_d   = StExec;
        end else if (timer_expired) begin
          tx_data_d = RErr;
          state_d   = StSend;
        end
      end
      StExec: begin
        // EXEC both decodes a fresh command and completes one whose arguments arrived.
        state_d = StSend;
        if (cmd_q == CAck) begin
          tx_data_d = RAck;
        end else if (cmd_q == CStatus) begin
          tx_data_d = ovr_q;
        end else if ((cmd_q == CRead) || (cmd_q == CWrite)) begin
          if (!args_ok_q) begin
            state_d = StGetAddr;
          end else if (!addr_ok) begin
            tx_data_d = RErr;
          end else if (cmd_q == CRead) begin
            tx_data_d = rd_data;
          end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
              if (addr_q == DATA_W'(i)) begin
                regs_d[i] = data_q;
              end
            end
            tx_data_d = ROk;
          end
        end else begin
          tx_data_d = RErr;
        end
      end
      StSend: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bytes arriving while a command is being executed or answered are dropped.
  assign ovr_inc = rx_done &&
                   ((state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx));
  assign ovr_clr = (state_q == StSend) && (cmd_q == CStatus);

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_clr) begin
      ovr_d = ovr_inc ? DATA_W'(1) : '0;
    end else if (ovr_inc && (ovr_q != '1)) begin
      ovr_d = ovr_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      args_ok_q <= 1'b0;
      tx_data_q <= '0;
      ovr_q     <= '0;
      regs_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      args_ok_q <= args_ok_d;
      tx_data_q <= tx_data_d;
      ovr_q     <= ovr_d;
      regs_q    <= regs_d;
    end
  end

  assign tx_dato_in = tx_data_q;
  assign tx_start   = (state_q == StSend);
  assign busy       = (state_q != StIdle);
  assign reg_file   = regs_q;

endmodule
